timer_counter: RTL
==================

// Module: timer_counter
// PURPOSE
//  Memory-mapped countdown timer on the processor bus behind the system bridge, window 0x0000_7F00-0x0000_7F0B.
//  Consumes word-aligned load/store traffic from the MEM stage (PrAddr/PrWD/PrWE) and returns PrRD in the same cycle.
//  Raises an interrupt request to CP0 on expiry. Two modes: one-shot (mode 0) and auto-reload (mode 1).
// PARAMETERS
//  CNT_W    32  width of PRESET and COUNT; reads zero-extend to 32 bits
// PORTS
//  clk      in   1   system clock; all state updates on the rising edge
//  reset    in   1   asynchronous, active-low; 0 forces the reset state immediately
//  addr     in   2   word select = PrAddr[3:2]: 0 CTRL, 1 PRESET, 2 COUNT, 3 unmapped
//  we       in   1   write strobe, already qualified by bridge chip-select and pipeline flush
//  wd       in   32  write data (full word; the MEM stage rejects sub-word peripheral stores)
//  rd       out  32  read data, combinational from addr and current registers
//  irq      out  1   interrupt request to CP0 (HWInt[2])
// BEHAVIOUR
//  Registers: CTRL[0]=EN, CTRL[2:1]=MODE, CTRL[3]=IM (irq mask); CTRL[31:4] read 0, writes ignored.
//   PRESET R/W. COUNT read-only: writes to addr 2 ignored (the MEM stage already raises AdES, ExcCode 5).
//   addr 3 reads 0, writes ignored. MODE 2/3 reserved, behave as mode 0.
//  Reset: CTRL=0, PRESET=0, COUNT=0, int_flag=0, state=IDLE; rd follows regs, irq=0.
//  Writes take effect at the edge where we=1. rd reflects the post-edge value from the next cycle onward.
//  FSM, one transition per edge:
//   IDLE: EN=1 -> LOAD; else stay.
//   LOAD: COUNT<=PRESET -> CNT.
//   CNT : EN=0 -> IDLE, COUNT holds. COUNT>1 -> COUNT-1, stay. COUNT<=1 -> COUNT<=0, int_flag<=1 -> INT.
//   INT : mode 0 -> EN<=0, -> IDLE, int_flag stays set.
//         mode 1 -> int_flag<=0, -> LOAD.
//  irq = IM & int_flag; registered, glitch-free.
//   Mode 0: irq held until a CPU write to CTRL or PRESET clears int_flag.
//   Mode 1: irq is a 1-cycle pulse per period. Period = PRESET+2 cycles when PRESET>=1.
//  Latency: CTRL write with EN=1 at edge T -> LOAD at T+1, COUNT=PRESET at T+2, INT at T+2+max(PRESET,1).
//  Collisions:
//   CPU write to CTRL in the same cycle as the INT auto-clear of EN: the CPU value wins.
//   CPU write to CTRL/PRESET in the same cycle int_flag would set: the set wins.
//  PRESET written during CNT: current count unaffected; new value used at the next LOAD.
//  EN cleared mid-count: IDLE next edge, COUNT frozen. Re-enable reloads from PRESET (no resume).
//  PRESET=0: LOAD->CNT->INT, same as PRESET=1. COUNT never wraps below 0.
//  Reset asserted mid-count: all state to reset values asynchronously; irq drops without waiting for an edge.
// TESTING
//  1 Reset: hold reset=0 with random bus traffic -> rd=0 at all addrs, irq=0. Release -> state IDLE.
//  2 One-shot: PRESET=3, CTRL=0x9 (EN,IM,mode0) at edge T -> COUNT 3,2,1,0 at T+2..T+5.
//    irq=1 from T+5, CTRL reads 0x8 at T+6. Write CTRL=0 -> irq=0 next cycle.
//  3 Auto-reload: PRESET=3, CTRL=0xB -> irq 1-cycle pulses every 5 cycles, at least 4 periods, COUNT reloads to 3 each time.
//  4 Masking/RO: CTRL=0x1 (IM=0) expiry -> irq stays 0 and int_flag is set; CTRL=0x9 -> irq=1 next cycle.
//    Write 0x55 to addr 2 -> COUNT unchanged. Addr 3 reads 0.
//  5 Disable/preset change mid-count: PRESET=10, enable, at COUNT=6 write PRESET=2 -> still expires after 10.
//    Clear EN at COUNT=4 -> COUNT stays 4. Re-enable -> reloads 2.
//  6 Collision + async reset: write CTRL=0x9 in the INT cycle of mode 0 -> EN stays 1, timer restarts.
//    Assert reset between edges mid-CNT -> COUNT=0, irq=0 before the next edge.

Source files
------------

// File: rtl/timer_counter.sv
// Memory-mapped countdown timer: CTRL/PRESET/COUNT word registers, one-shot or
// auto-reload expiry, registered interrupt request gated by the CTRL mask bit.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] wd,
  output logic [31:0] rd,
  output logic        irq
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e           state_q, state_d;
  logic [3:0]       ctrl_q, ctrl_d;
  logic [CNT_W-1:0] preset_q, preset_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flag_q, flag_d;
  logic             irq_q, irq_d;

  logic en, mode1, wr_ctrl, wr_pre, cpu_clr, expire;

  assign en      = ctrl_q[0];
  assign mode1   = (ctrl_q[2:1] == 2'b01);
  assign wr_ctrl = we && (addr == 2'd0);
  assign wr_pre  = we && (addr == 2'd1);
  // A CTRL write that unmasks (IM 0->1) keeps a pending flag so it can be taken.
  assign cpu_clr = wr_pre || (wr_ctrl && !(wd[3] && !ctrl_q[3]));
  assign expire  = (state_q == CNT) && en && (count_q <= CNT_W'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      ctrl_q   <= '0;
      preset_q <= '0;
      count_q  <= '0;
      flag_q   <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      preset_q <= preset_d;
      count_q  <= count_d;
      flag_q   <= flag_d;
      irq_q    <= irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en) state_d = LOAD;
      LOAD:    state_d = CNT;
      CNT:     if (!en) state_d = IDLE;
               else if (expire) state_d = INT;
      INT:     state_d = mode1 ? LOAD : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d   = ctrl_q;
    preset_d = preset_q;
    count_d  = count_q;
    flag_d   = flag_q;
    if (state_q == INT && !mode1) ctrl_d[0] = 1'b0;
    if (wr_ctrl) ctrl_d = wd[3:0];
    if (wr_pre)  preset_d = wd[CNT_W-1:0];
    if (state_q == LOAD) count_d = preset_q;
    else if (state_q == CNT && en)
      count_d = (count_q > CNT_W'(1)) ? count_q - CNT_W'(1) : '0;
    if (cpu_clr || (state_q == INT && mode1)) flag_d = 1'b0;
    // Expiry set beats any same-cycle clear.
    if (expire) flag_d = 1'b1;
    irq_d = ctrl_d[3] && flag_d;
  end

  always_comb begin
    rd = '0;
    case (addr)
      2'd0:    rd = {28'b0, ctrl_q};
      2'd1:    rd = 32'(preset_q);
      2'd2:    rd = 32'(count_q);
      default: rd = '0;
    endcase
  end

  assign irq = irq_q;

endmodule
